// File: rtl/fsk4_mod.sv
// fsk4_mod: continuous-phase 4FSK modulator.
// Pairs serial bits from the shared bit timebase into Gray-coded symbols,
// steps a phase accumulator by a per-symbol increment and shapes the
// accumulator into an 8-bit triangle sample for the DAC/channel model.
module fsk4_mod #(
  parameter int ACC_W     = 16,
  parameter int FREQ0     = 256,
  parameter int FREQ1     = 512,
  parameter int FREQ2     = 768,
  parameter int FREQ3     = 1024,
  parameter int SAMPLE_PH = 128
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] phase,
  input  logic [3:0] sign_cnt,
  input  logic       in_bit,
  input  logic       tx_en,
  output logic [1:0] sym_out,
  output logic       sym_strobe,
  output logic       tx_active,
  output logic       nco_msb,
  output logic [7:0] fsk_sample
);

  localparam logic [7:0] SAMPLE_MID = 8'd128;

  // ---------------------------------------------------------------------
  // Timebase decode (phase/sign_cnt are owned by the shared timebase)
  // ---------------------------------------------------------------------
  logic phase_last;
  logic sample_hit;
  logic commit_hit;
  logic frame_hit;

  assign phase_last = (phase == 8'd255);
  assign sample_hit = (phase == SAMPLE_PH[7:0]);
  // A symbol is complete at the last clock of every odd bit period.
  assign commit_hit = phase_last & sign_cnt[0];
  // The frame boundary is also the commit of bits 14/15.
  assign frame_hit  = phase_last & (sign_cnt == 4'd15);

  // ---------------------------------------------------------------------
  // Gray-coded increment table: index is the symbol value {hi,lo};
  // 00->FREQ0, 01->FREQ1, 11->FREQ2, 10->FREQ3 so adjacent tones differ
  // by one bit.
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] inc_tbl [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_inc
      localparam int GRAY_FREQ = (gi == 0) ? FREQ0 :
                                 (gi == 1) ? FREQ1 :
                                 (gi == 3) ? FREQ2 : FREQ3;
      assign inc_tbl[gi] = ACC_W'(GRAY_FREQ);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic             b_hi_reg;
  logic             b_lo_reg;
  logic             run_reg;
  logic [1:0]       sym_reg;
  logic             strobe_reg;
  logic             active_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             msb_reg;
  logic             msb_next;
  logic [7:0]       sample_reg;
  logic [7:0]       sample_next;
  logic [7:0]       tri_t;

  // Mid-bit sampling: even bit index fills the symbol MSB, odd the LSB.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      b_hi_reg <= 1'b0;
      b_lo_reg <= 1'b0;
    end else if (sample_hit) begin
      if (sign_cnt[0]) begin
        b_lo_reg <= in_bit;
      end else begin
        b_hi_reg <= in_bit;
      end
    end
  end

  // Transmit request is latched only at the frame boundary so a frame
  // is either fully modulated or not at all.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      run_reg <= 1'b0;
    end else if (frame_hit) begin
      run_reg <= tx_en;
    end
  end

  // Symbol commit; tx_active takes the pre-update run flag so bits 14/15
  // of a running frame are still modulated during bits 0/1 of the next.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sym_reg    <= 2'b00;
      strobe_reg <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      strobe_reg <= commit_hit;
      if (commit_hit) begin
        sym_reg    <= {b_hi_reg, b_lo_reg};
        active_reg <= run_reg;
      end
    end
  end

  // NCO step selection; the accumulator is never cleared on a symbol
  // change, which keeps the output phase continuous.
  always_comb begin
    acc_next = acc_reg;
    if (active_reg) begin
      acc_next = acc_reg + inc_tbl[sym_reg];
    end
  end

  // Phase accumulator register (wraps naturally modulo 2^ACC_W).
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  // Triangle shaping: fold the upper half of the phase circle downwards.
  assign tri_t = acc_reg[ACC_W-2 -: 8];

  // Output shaping from the current accumulator; mid-scale when idle.
  always_comb begin
    sample_next = SAMPLE_MID;
    msb_next    = 1'b0;
    if (active_reg) begin
      sample_next = acc_reg[ACC_W-1] ? ~tri_t : tri_t;
      msb_next    = acc_reg[ACC_W-1];
    end
  end

  // Output register, one clock behind the accumulator.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sample_reg <= SAMPLE_MID;
      msb_reg    <= 1'b0;
    end else begin
      sample_reg <= sample_next;
      msb_reg    <= msb_next;
    end
  end

  assign sym_out    = sym_reg;
  assign sym_strobe = strobe_reg;
  assign tx_active  = active_reg;
  assign nco_msb    = msb_reg;
  assign fsk_sample = sample_reg;

endmodule
